// File: rtl/cby_param_shadow.sv
// cby_param_shadow -- parametrised Y-direction connection block.
//
// CHAN_WIDTH vertical tracks pass straight through in both directions.
// NUM_IPIN grid input pins are each driven by a MUX_SIZE:1 multiplexer whose
// taps alternate bottom/top tracks.
//
// The configuration chain segment is double-buffered. Bits shift into sr
// while a counter tracks how many have arrived. They are copied into the
// shadow register, which drives the muxes, only on a validated commit.
// Routing therefore never glitches while the chain is being programmed.
//
// Optional feature: define CBY_PARITY_EN to append one even-parity bit to
// the chain. That bit is the first one shifted, so it lands in sr[L-1].
// A commit is then accepted only if the XOR over the whole chain is 0.
module cby_param_shadow #(
  parameter int CHAN_WIDTH = 11,
  parameter int NUM_IPIN   = 9,
  parameter int MUX_SIZE   = 6,
  parameter int TAP_STRIDE = 5
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_commit,
  output logic                  ccff_tail,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  cfg_valid,
  output logic                  cfg_err
);

  localparam int SEL_W  = $clog2(MUX_SIZE);
  localparam int DATA_W = NUM_IPIN * SEL_W;
`ifdef CBY_PARITY_EN
  localparam int L = DATA_W + 1;
`else
  localparam int L = DATA_W;
`endif
  localparam int                  CNT_W   = $clog2(L + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(L);
  localparam logic [SEL_W:0]      MUX_LIM  = (SEL_W + 1)'(MUX_SIZE);

  logic [1:0]       rst_sync;
  logic             run;
  logic [L-1:0]     sr;
  logic [L-1:0]     shadow;
  logic [CNT_W-1:0] cnt;
  logic             parity_ok;

  // The tracks pass straight through and are independent of configuration.
  assign chany_bottom_out = chany_top_in;
  assign chany_top_out    = chany_bottom_in;
  assign ccff_tail        = sr[L-1];

`ifdef CBY_PARITY_EN
  assign parity_ok = ~(^sr);
`else
  assign parity_ok = 1'b1;
`endif

  // Release synchroniser: chain activity resumes on the third edge after
  // pReset rises.
  // NOTE: assertion is asynchronous, but de-assertion is re-timed to
  // prog_clk so that every chain flop leaves reset on the same edge.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // Shift chain, bit counter, shadow commit and sticky error flag.
  // NOTE: all state here uses non-blocking assignments, so the commit reads
  // sr and cnt as they were before any shift on the same edge.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sr        <= '0;
      shadow    <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (run) begin
      if (ccff_en) sr <= {sr[L-2:0], ccff_head};

      if (ccff_commit && cnt == CNT_FULL) begin
        if (parity_ok) begin
          shadow    <= sr;
          cfg_valid <= 1'b1;
          cnt       <= ccff_en ? CNT_W'(1) : '0;
        end else begin
          cfg_err <= 1'b1;
          cnt     <= '0;
        end
      end else begin
        if (ccff_commit) cfg_err <= 1'b1;
        if (ccff_en && cnt != CNT_FULL) cnt <= cnt + 1'b1;
      end
    end
  end

  // Per-pin mux: the select is MSB-first from shadow.
  // Tap pair k reads track (i + k*TAP_STRIDE) mod CHAN_WIDTH.
  // An even input takes the bottom track and an odd input takes the top track.
  for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
    logic [MUX_SIZE-1:0] mux_in;
    logic [SEL_W-1:0]    sel;

    for (genvar gk = 0; gk < MUX_SIZE / 2; gk++) begin : g_tap
      localparam int T = (gi + gk * TAP_STRIDE) % CHAN_WIDTH;
      assign mux_in[2*gk]   = chany_bottom_in[T];
      assign mux_in[2*gk+1] = chany_top_in[T];
    end

    for (genvar gb = 0; gb < SEL_W; gb++) begin : g_sel
      assign sel[SEL_W-1-gb] = shadow[gi*SEL_W+gb];
    end

    assign ipin_out[gi] = (cfg_valid && ({1'b0, sel} < MUX_LIM)) ? mux_in[sel] : 1'b0;
  end

endmodule

// File: tb/tb_cby_param_shadow.sv
// Directed testbench for cby_param_shadow at its default parameters.
// The parity tests are built only when CBY_PARITY_EN is defined.
module tb_cby_param_shadow;

  localparam int CW = 11;
  localparam int NP = 9;
  localparam int MS = 6;
  localparam int TS = 5;
  localparam int SW = 3;
`ifdef CBY_PARITY_EN
  localparam int L = NP * SW + 1;
`else
  localparam int L = NP * SW;
`endif

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b0;
  logic [CW-1:0] chany_bottom_in = '0;
  logic [CW-1:0] chany_top_in    = '0;
  logic [CW-1:0] chany_bottom_out;
  logic [CW-1:0] chany_top_out;
  logic          ccff_head   = 1'b0;
  logic          ccff_en     = 1'b0;
  logic          ccff_commit = 1'b0;
  logic          ccff_tail;
  logic [NP-1:0] ipin_out;
  logic          cfg_valid;
  logic          cfg_err;

  cby_param_shadow dut (
    .prog_clk         (prog_clk),
    .pReset           (pReset),
    .chany_bottom_in  (chany_bottom_in),
    .chany_top_in     (chany_top_in),
    .chany_bottom_out (chany_bottom_out),
    .chany_top_out    (chany_top_out),
    .ccff_head        (ccff_head),
    .ccff_en          (ccff_en),
    .ccff_commit      (ccff_commit),
    .ccff_tail        (ccff_tail),
    .ipin_out         (ipin_out),
    .cfg_valid        (cfg_valid),
    .cfg_err          (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  int tests = 0;
  int fails = 0;

  logic [2:0] sel_tb [NP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chain image for the current sel_tb.
  // Pin i select MSB sits at bit i*SW, and the parity bit (if any) at L-1.
  function automatic logic [L-1:0] build_cfg();
    logic [L-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++)
      for (int b = 0; b < SW; b++)
        v[i*SW+b] = sel_tb[i][SW-1-b];
`ifdef CBY_PARITY_EN
    v[L-1] = ^v[L-2:0];
`endif
    return v;
  endfunction

  // Expected pin drives for a committed sel_tb and the given tracks.
  function automatic logic [NP-1:0] model_ipin(input logic [CW-1:0] bot, input logic [CW-1:0] top);
    logic [NP-1:0] r;
    int t;
    r = '0;
    for (int i = 0; i < NP; i++) begin
      if (int'(sel_tb[i]) < MS) begin
        t = (i + (int'(sel_tb[i]) / 2) * TS) % CW;
        r[i] = sel_tb[i][0] ? top[t] : bot[t];
      end
    end
    return r;
  endfunction

  task automatic shift(input logic b);
    ccff_en   = 1'b1;
    ccff_head = b;
    @(posedge prog_clk); #1;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  // Shifts the image in from its top bit down, so that v[j] ends in sr[j].
  task automatic load(input logic [L-1:0] v);
    for (int j = L - 1; j >= 0; j--) shift(v[j]);
  endtask

  task automatic commit();
    ccff_commit = 1'b1;
    @(posedge prog_clk); #1;
    ccff_commit = 1'b0;
  endtask

  task automatic set_tracks(input logic [CW-1:0] bot, input logic [CW-1:0] top);
    chany_bottom_in = bot;
    chany_top_in    = top;
  endtask

  logic [L-1:0]  cfg;
  logic [NP-1:0] prev_ipin;
  logic [CW-1:0] rb, rt;

  initial begin
    // Reset held: toggle every input.
    for (int n = 0; n < 4; n++) begin
      @(posedge prog_clk); #1;
      set_tracks(CW'($urandom), CW'($urandom));
      ccff_head   = 1'($urandom);
      ccff_en     = 1'($urandom);
      ccff_commit = 1'($urandom);
      #1;
      check("rst_ipin",  32'(ipin_out),  32'h0);
      check("rst_valid", 32'(cfg_valid), 32'h0);
      check("rst_err",   32'(cfg_err),   32'h0);
      check("rst_tail",  32'(ccff_tail), 32'h0);
      check("pass_top",  32'(chany_top_out),    32'(chany_bottom_in));
      check("pass_bot",  32'(chany_bottom_out), 32'(chany_top_in));
    end
    ccff_en = 1'b0; ccff_commit = 1'b0; ccff_head = 1'b0;
    set_tracks('0, '0);
    pReset = 1'b1;
    repeat (2) begin @(posedge prog_clk); #1; end

    // Full load and commit: pin 0 sel=2, all other pins sel=0.
    for (int i = 0; i < NP; i++) sel_tb[i] = 3'd0;
    sel_tb[0] = 3'd2;
    cfg = build_cfg();
    load(cfg);
    check("pre_commit_valid", 32'(cfg_valid), 32'h0);
    check("load_tail", 32'(ccff_tail), 32'(cfg[L-1]));
    commit();
    set_tracks(CW'(1) << 5, '0);
    @(posedge prog_clk); #1;
    check("commit_valid", 32'(cfg_valid), 32'h1);
    check("commit_err",   32'(cfg_err),   32'h0);
    check("commit_pin0",  32'(ipin_out[0]), 32'h1);
    check("commit_ipin",  32'(ipin_out), 32'h021);
    set_tracks('0, CW'(1) << 5);
    #1;
    check("commit_top5",  32'(ipin_out), 32'(model_ipin(chany_bottom_in, chany_top_in)));

    // Premature commit after 10 shifts.
    set_tracks(CW'(1) << 5, '0);
    prev_ipin = ipin_out;
    #1;
    prev_ipin = ipin_out;
    for (int n = 0; n < 10; n++) shift(1'b1);
    commit();
    check("early_err",   32'(cfg_err),   32'h1);
    check("early_valid", 32'(cfg_valid), 32'h1);
    check("early_ipin",  32'(ipin_out),  32'(prev_ipin));

    // Out-of-range select on pin 3, plus a spread of in-range selects.
    sel_tb[0] = 3'd2; sel_tb[1] = 3'd5; sel_tb[2] = 3'd4;
    sel_tb[3] = 3'd7; sel_tb[4] = 3'd1; sel_tb[5] = 3'd3;
    sel_tb[6] = 3'd6; sel_tb[7] = 3'd0; sel_tb[8] = 3'd2;
    load(build_cfg());
    commit();
    set_tracks('1, '1);
    #1;
    check("oor_all_ones", 32'(ipin_out), 32'h1B7);
    for (int n = 0; n < 5; n++) begin
      rb = (n == 0) ? CW'(11'h555) : CW'($urandom);
      rt = (n == 0) ? CW'(11'h2AA) : CW'($urandom);
      set_tracks(rb, rt);
      #1;
      check("oor_pin3", 32'(ipin_out[3]), 32'h0);
      check("oor_route", 32'(ipin_out), 32'(model_ipin(rb, rt)));
    end

    // Chain timing: a single 1 appears at the tail L shifts later.
    shift(1'b0);
    shift(1'b1);
    for (int n = 0; n < L - 2; n++) shift(1'b0);
    check("tail_before", 32'(ccff_tail), 32'h0);
    shift(1'b0);
    check("tail_at_L", 32'(ccff_tail), 32'h1);
    shift(1'b0);
    check("tail_after", 32'(ccff_tail), 32'h0);

    // Reset mid-load at shift 13.
    for (int n = 0; n < 12; n++) shift(1'b1);
    ccff_en = 1'b1; ccff_head = 1'b1;
    pReset  = 1'b0;
    #1;
    ccff_en = 1'b0;
    check("midrst_valid", 32'(cfg_valid), 32'h0);
    check("midrst_err",   32'(cfg_err),   32'h0);
    check("midrst_ipin",  32'(ipin_out),  32'h0);
    check("midrst_tail",  32'(ccff_tail), 32'h0);
    @(posedge prog_clk); #1;
    pReset = 1'b1;
    shift(1'b1);
    shift(1'b1);
    sel_tb[0] = 3'd1; sel_tb[1] = 3'd0; sel_tb[2] = 3'd3;
    sel_tb[3] = 3'd5; sel_tb[4] = 3'd2; sel_tb[5] = 3'd4;
    sel_tb[6] = 3'd1; sel_tb[7] = 3'd5; sel_tb[8] = 3'd0;
    cfg = build_cfg();
    for (int j = L - 1; j >= 2; j--) shift(cfg[j]);
    check("sync_ignored", 32'(ccff_tail), 32'h0);
    shift(cfg[1]);
    shift(cfg[0]);
    commit();
    check("reload_valid", 32'(cfg_valid), 32'h1);
    check("reload_err",   32'(cfg_err),   32'h0);
    set_tracks(11'h3C5, 11'h1A6);
    #1;
    check("reload_route", 32'(ipin_out), 32'(model_ipin(11'h3C5, 11'h1A6)));

`ifdef CBY_PARITY_EN
    // Odd parity is rejected; even parity is applied.
    prev_ipin = ipin_out;
    cfg = build_cfg();
    cfg[L-1] = ~cfg[L-1];
    load(cfg);
    commit();
    check("par_odd_err",   32'(cfg_err),   32'h1);
    check("par_odd_valid", 32'(cfg_valid), 32'h1);
    check("par_odd_ipin",  32'(ipin_out),  32'(prev_ipin));
    sel_tb[0] = 3'd3; sel_tb[1] = 3'd1; sel_tb[2] = 3'd2;
    load(build_cfg());
    commit();
    check("par_even_valid", 32'(cfg_valid), 32'h1);
    check("par_even_route", 32'(ipin_out), 32'(model_ipin(11'h3C5, 11'h1A6)));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
